// File: rtl/ram_pkg.sv
// Shared definitions for the byte-masked true dual-port RAM family.
package ram_pkg;

    // Cross-port read-during-write behaviour
    localparam int unsigned RD_OLD = 0;
    localparam int unsigned RD_NEW = 1;

    // Widest word and lane count byte_merge can handle
    localparam int unsigned MERGE_MAX_DW = 256;
    localparam int unsigned MERGE_MAX_NB = 256;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_e;

    // Lane-wise merge: bits in lanes with ben set come from din, the rest from old_word
    function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
        input logic [MERGE_MAX_DW-1:0] old_word,
        input logic [MERGE_MAX_DW-1:0] din,
        input logic [MERGE_MAX_NB-1:0] ben,
        input int unsigned             byte_width
    );
        logic [MERGE_MAX_DW-1:0] res;
        res = old_word;
        for (int unsigned j = 0; j < MERGE_MAX_DW; j++) begin
            if (ben[8'(j / byte_width)]) res[j] = din[j];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read output stage: one or two register stages ending in dout/dvld.
module ram_rd_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_dvld,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic                  w_vld_pre;
    logic [DATA_WIDTH-1:0] w_data_pre;
    logic                  r_dvld;
    logic [DATA_WIDTH-1:0] r_dout;

    generate
        if (READ_LATENCY == 2) begin : g_two
            logic                  r_vld_s1;
            logic [DATA_WIDTH-1:0] r_data_s1;

            // Extra pipeline stage ahead of the output register
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_vld_s1  <= 1'b0;
                    r_data_s1 <= '0;
                end else begin
                    r_vld_s1 <= i_vld;
                    if (i_vld) r_data_s1 <= i_data;
                end
            end

            assign w_vld_pre  = r_vld_s1;
            assign w_data_pre = r_data_s1;
        end else begin : g_one
            assign w_vld_pre  = i_vld;
            assign w_data_pre = i_data;
        end
    endgenerate

    // Output register: dout holds until the next completed read, dvld pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dvld <= 1'b0;
            r_dout <= '0;
        end else begin
            r_dvld <= w_vld_pre;
            if (w_vld_pre) r_dout <= w_data_pre;
        end
    end

    assign o_dvld = r_dvld;
    assign o_dout = r_dout;

endmodule

// File: rtl/ram_tdp_bytemask_clr.sv
// True dual-port RAM with byte write enables, collision resolution and a clear engine.
module ram_tdp_bytemask_clr
    import ram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned BYTE_WIDTH   = 8,
    parameter  int unsigned DEPTH        = 16,
    parameter  int unsigned READ_LATENCY = 1,
    parameter  int unsigned READ_MODE    = RD_OLD,
    localparam int unsigned ADDR_WIDTH   = $clog2(DEPTH),
    localparam int unsigned NB           = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_cen,
    input  logic                  i_clr_req,
    output logic                  o_busy,
    input  logic                  i_wen_a,
    input  logic [NB-1:0]         i_ben_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    output logic [DATA_WIDTH-1:0] o_dout_a,
    output logic                  o_dvld_a,
    input  logic                  i_wen_b,
    input  logic [NB-1:0]         i_ben_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [DATA_WIDTH-1:0] i_din_b,
    output logic [DATA_WIDTH-1:0] o_dout_b,
    output logic                  o_dvld_b,
    output logic                  o_collision
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    clr_state_e            r_state;
    clr_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic                  r_collision;
    logic                  w_clr_we;
    logic                  w_cnt_last;
    logic                  w_op_en;
    logic                  w_rng_a, w_rng_b;
    logic                  w_wr_a, w_wr_b, w_rd_a, w_rd_b;
    logic                  w_same;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_new_a, w_new_b;
    logic [DATA_WIDTH-1:0] w_rdata_a, w_rdata_b;

    assign w_cnt_last = (r_cnt == ADDR_WIDTH'(DEPTH - 1));

    // Clear FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // Clear FSM next state: sweep to the last word, restart only from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_cnt_last) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (i_clr_req)  w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        w_clr_we = 1'b0;
        if (r_state == ST_CLEAR) w_clr_we = 1'b1;
    end

    // Sweep counter and busy flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else begin
            r_busy <= (w_state_nxt == ST_CLEAR);
            if (w_clr_we && !w_cnt_last) r_cnt <= r_cnt + ADDR_WIDTH'(1);
            else                         r_cnt <= '0;
        end
    end

    assign w_op_en = i_cen & ~r_busy;
    assign w_rng_a = (32'(i_addr_a) < DEPTH);
    assign w_rng_b = (32'(i_addr_b) < DEPTH);
    assign w_wr_a  = w_op_en & i_wen_a & w_rng_a;
    assign w_wr_b  = w_op_en & i_wen_b & w_rng_b;
    assign w_rd_a  = w_op_en & ~i_wen_a;
    assign w_rd_b  = w_op_en & ~i_wen_b;
    assign w_same  = (i_addr_a == i_addr_b);

    assign w_old_a = w_rng_a ? r_mem[i_addr_a] : '0;
    assign w_old_b = w_rng_b ? r_mem[i_addr_b] : '0;

    // B merges first so that on a same-address write A's lanes land on top
    assign w_new_b = DATA_WIDTH'(byte_merge(MERGE_MAX_DW'(w_old_b), MERGE_MAX_DW'(i_din_b),
                                            MERGE_MAX_NB'(i_ben_b), BYTE_WIDTH));
    assign w_new_a = DATA_WIDTH'(byte_merge(MERGE_MAX_DW'((w_wr_b && w_same) ? w_new_b : w_old_a),
                                            MERGE_MAX_DW'(i_din_a), MERGE_MAX_NB'(i_ben_a),
                                            BYTE_WIDTH));

    // Read data: zero out of range, optionally forward the other port's write
    assign w_rdata_a = !w_rng_a ? '0 :
                       ((READ_MODE == RD_NEW) && w_wr_b && w_same) ? w_new_b : w_old_a;
    assign w_rdata_b = !w_rng_b ? '0 :
                       ((READ_MODE == RD_NEW) && w_wr_a && w_same) ? w_new_a : w_old_b;

    // Storage: clear sweep or port writes; a same-address pair commits once via A
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr_a)                       r_mem[i_addr_a] <= w_new_a;
            if (w_wr_b && !(w_wr_a && w_same)) r_mem[i_addr_b] <= w_new_b;
        end
    end

    // Collision flag: both ports wrote overlapping lanes of one in-range word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_collision <= 1'b0;
        else       r_collision <= w_wr_a & w_wr_b & w_same & (|(i_ben_a & i_ben_b));
    end

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_a (
        .clock  (clock),
        .reset  (reset),
        .i_vld  (w_rd_a),
        .i_data (w_rdata_a),
        .o_dvld (o_dvld_a),
        .o_dout (o_dout_a)
    );

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_b (
        .clock  (clock),
        .reset  (reset),
        .i_vld  (w_rd_b),
        .i_data (w_rdata_b),
        .o_dvld (o_dvld_b),
        .o_dout (o_dout_b)
    );

    assign o_busy      = r_busy;
    assign o_collision = r_collision;

endmodule
